sqrt_seq: RTL and testbench

SQRT_SEQ -- requirements
Module: sqrt_seq

---
 rtl/sqrt_seq_if.sv | 30 +++
 rtl/sqrt_seq.sv | 122 ++++++++++++
 tb/tb_sqrt_seq.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/sqrt_seq_if.sv
// Operand/result handshake bundle for sqrt_seq: operand + side-band in, root + remainder + side-band out.
// The master drives operands and accepts results; the slave is the square-root engine.
interface sqrt_seq_if #(
  parameter int IN_W = 32,
  parameter int G_W  = 16
);
  logic                in_valid;
  logic                in_ready;
  logic [IN_W-1:0]     e;
  logic [G_W-1:0]      g0_in;
  logic [G_W-1:0]      g1_in;
  logic [1:0]          quad_in;
  logic                out_valid;
  logic                out_ready;
  logic [IN_W/2-1:0]   f;
  logic [IN_W/2:0]     rem;
  logic [G_W-1:0]      g0;
  logic [G_W-1:0]      g1;
  logic [1:0]          quad;

  modport master (
    output in_valid, e, g0_in, g1_in, quad_in, out_ready,
    input  in_ready, out_valid, f, rem, g0, g1, quad
  );

  modport slave (
    input  in_valid, e, g0_in, g1_in, quad_in, out_ready,
    output in_ready, out_valid, f, rem, g0, g1, quad
  );
endinterface

// File: rtl/sqrt_seq.sv
// Sequential integer square root: restoring radix-2 digit recurrence, one root bit per cycle,
// with optional round-to-nearest and side-band samples carried alongside each operand.
module sqrt_seq #(
  parameter int IN_W  = 32,
  parameter int G_W   = 16,
  parameter int ROUND = 0
) (
  input  logic      clk,
  input  logic      rst,
  sqrt_seq_if.slave bus
);
  localparam int HW = IN_W / 2;
  localparam int RW = HW + 1;
  localparam int CW = $clog2(HW + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IN_W-1:0]  x_q, x_d;
  logic [HW-1:0]    root_q, root_d;
  logic [RW-1:0]    acc_q, acc_d;
  logic [HW-1:0]    f_q, f_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic [G_W-1:0]   g0_q, g0_d, g1_q, g1_d;
  logic [1:0]       quad_q, quad_d;

  logic [RW+1:0]    shifted;
  logic [RW+1:0]    trial;
  logic             ge;
  logic [HW-1:0]    rootNext;
  logic [RW-1:0]    accNext;

  // One recurrence step: bring down two radicand bits, try subtracting 4*root+1.
  // The partial remainder never exceeds 2*root, so it fits in HW+1 bits.
  always_comb begin
    shifted  = {acc_q, x_q[IN_W-1 -: 2]};
    trial    = {1'b0, root_q, 2'b01};
    ge       = (shifted >= trial);
    rootNext = {root_q[HW-2:0], ge};
    accNext  = ge ? RW'(shifted - trial) : RW'(shifted);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      root_q  <= '0;
      acc_q   <= '0;
      f_q     <= '0;
      rem_q   <= '0;
      g0_q    <= '0;
      g1_q    <= '0;
      quad_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      root_q  <= root_d;
      acc_q   <= acc_d;
      f_q     <= f_d;
      rem_q   <= rem_d;
      g0_q    <= g0_d;
      g1_q    <= g1_d;
      quad_q  <= quad_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    root_d  = root_q;
    acc_d   = acc_q;
    f_d     = f_q;
    rem_d   = rem_q;
    g0_d    = g0_q;
    g1_d    = g1_q;
    quad_d  = quad_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          x_d     = bus.e;
          root_d  = '0;
          acc_d   = '0;
          cnt_d   = CW'(HW);
          g0_d    = bus.g0_in;
          g1_d    = bus.g1_in;
          quad_d  = bus.quad_in;
          state_d = CALC;
        end
      end
      CALC: begin
        x_d    = {x_q[IN_W-3:0], 2'b00};
        root_d = rootNext;
        acc_d  = accNext;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          f_d     = rootNext;
          rem_d   = accNext;
          // rem > f means e is closer to (f+1)^2; an all-ones root cannot go higher.
          if ((ROUND != 0) && (accNext > {1'b0, rootNext}) && !(&rootNext))
            f_d = rootNext + HW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.f         = f_q;
  assign bus.rem       = rem_q;
  assign bus.g0        = g0_q;
  assign bus.g1        = g1_q;
  assign bus.quad      = quad_q;
endmodule

// File: tb/tb_sqrt_seq.sv
// Directed bench for sqrt_seq: a floor instance and a round-to-nearest instance driven with
// identical stimulus, each result compared against hand-computed roots and remainders.
module tb_sqrt_seq;
  logic clk;
  logic rst;
  int   nChecks;
  int   nFail;

  sqrt_seq_if #(.IN_W(32), .G_W(16)) b0 ();
  sqrt_seq_if #(.IN_W(32), .G_W(16)) b1 ();

  sqrt_seq #(.IN_W(32), .G_W(16), .ROUND(0)) dutFloor (.clk(clk), .rst(rst), .bus(b0.slave));
  sqrt_seq #(.IN_W(32), .G_W(16), .ROUND(1)) dutRound (.clk(clk), .rst(rst), .bus(b1.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Directed vectors: radicand, floor root, remainder, rounded root.
  logic [31:0] vecE  [9] = '{32'd0, 32'd144, 32'd150, 32'd157, 32'd155, 32'hFFFFFFFF, 32'd1, 32'd3, 32'd8};
  logic [15:0] vecF  [9] = '{16'd0, 16'd12, 16'd12, 16'd12, 16'd12, 16'hFFFF, 16'd1, 16'd1, 16'd2};
  logic [16:0] vecR  [9] = '{17'd0, 17'd0, 17'd6, 17'd13, 17'd11, 17'd131070, 17'd0, 17'd2, 17'd4};
  logic [15:0] vecFR [9] = '{16'd0, 16'd12, 16'd12, 16'd13, 16'd12, 16'hFFFF, 16'd1, 16'd2, 16'd3};

  task automatic applyStimulus(input logic v, input logic [31:0] ev, input logic [15:0] g0v,
                               input logic [15:0] g1v, input logic [1:0] qv);
    b0.in_valid = v;  b1.in_valid = v;
    b0.e = ev;        b1.e = ev;
    b0.g0_in = g0v;   b1.g0_in = g0v;
    b0.g1_in = g1v;   b1.g1_in = g1v;
    b0.quad_in = qv;  b1.quad_in = qv;
  endtask

  task automatic setReady(input logic r);
    b0.out_ready = r;
    b1.out_ready = r;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    applyStimulus(1'b1, 32'd50, 16'h1111, 16'h2222, 2'd1);
    setReady(1'b1);
    repeat (2) @(posedge clk);
    #1;
    nChecks++;
    if (b0.out_valid !== 1'b0 || b0.f !== 16'd0 || b0.rem !== 17'd0 || b0.g0 !== 16'd0 ||
        b0.g1 !== 16'd0 || b0.quad !== 2'd0) begin
      nFail++;
      $display("[TB] FAIL reset_outputs: got valid=%b f=%0d rem=%0d g0=%h g1=%h quad=%0d, expected all zero",
               b0.out_valid, b0.f, b0.rem, b0.g0, b0.g1, b0.quad);
    end
    nChecks++;
    if (b0.in_ready !== 1'b1 || b1.in_ready !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL reset_priority: got in_ready=%b/%b, expected 1/1", b0.in_ready, b1.in_ready);
    end
    rst = 1'b0;
    applyStimulus(1'b0, 32'd0, 16'd0, 16'd0, 2'd0);
    setReady(1'b0);
    @(posedge clk);
    #1;
    nChecks++;
    if (b0.in_ready !== 1'b1 || b0.out_valid !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL after_reset_idle: got in_ready=%b out_valid=%b, expected 1 0", b0.in_ready, b0.out_valid);
    end
  endtask

  task automatic test_vectors();
    int cycles;
    logic [15:0] g0v, g1v;
    logic [1:0]  qv;
    for (int i = 0; i < 9; i++) begin
      g0v = 16'(i * 3 + 1);
      g1v = 16'(16'hF000 + i);
      qv  = 2'(i);
      @(negedge clk);
      applyStimulus(1'b1, vecE[i], g0v, g1v, qv);
      @(posedge clk);
      #1;
      applyStimulus(1'b0, 32'd0, 16'd0, 16'd0, 2'd0);
      cycles = 0;
      while (b0.out_valid !== 1'b1 && cycles < 40) begin
        @(posedge clk);
        #1;
        cycles++;
      end
      nChecks++;
      if (cycles != 16 || b1.out_valid !== 1'b1) begin
        nFail++;
        $display("[TB] FAIL latency e=%0d: got %0d cycles (round valid=%b), expected 16", vecE[i], cycles, b1.out_valid);
      end
      nChecks++;
      if (b0.f !== vecF[i] || b0.rem !== vecR[i]) begin
        nFail++;
        $display("[TB] FAIL floor e=%0d: got f=%0d rem=%0d, expected f=%0d rem=%0d",
                 vecE[i], b0.f, b0.rem, vecF[i], vecR[i]);
      end
      nChecks++;
      if (b1.f !== vecFR[i] || b1.rem !== vecR[i]) begin
        nFail++;
        $display("[TB] FAIL round e=%0d: got f=%0d rem=%0d, expected f=%0d rem=%0d",
                 vecE[i], b1.f, b1.rem, vecFR[i], vecR[i]);
      end
      nChecks++;
      if (b0.g0 !== g0v || b0.g1 !== g1v || b0.quad !== qv) begin
        nFail++;
        $display("[TB] FAIL sideband e=%0d: got %h %h %0d, expected %h %h %0d",
                 vecE[i], b0.g0, b0.g1, b0.quad, g0v, g1v, qv);
      end
      setReady(1'b1);
      @(posedge clk);
      #1;
      setReady(1'b0);
      nChecks++;
      if (b0.in_ready !== 1'b1 || b0.out_valid !== 1'b0) begin
        nFail++;
        $display("[TB] FAIL handoff e=%0d: got in_ready=%b out_valid=%b, expected 1 0",
                 vecE[i], b0.in_ready, b0.out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    int cycles;
    @(negedge clk);
    applyStimulus(1'b1, 32'd150, 16'h1234, 16'hABCD, 2'd2);
    @(posedge clk);
    #1;
    // Competing operand held high through CALC and DONE must never be captured.
    applyStimulus(1'b1, 32'd4, 16'h5555, 16'h6666, 2'd1);
    cycles = 0;
    while (b0.out_valid !== 1'b1 && cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    nChecks++;
    if (cycles != 16) begin
      nFail++;
      $display("[TB] FAIL bp_latency: got %0d cycles, expected 16", cycles);
    end
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      nChecks++;
      if (b0.out_valid !== 1'b1 || b0.in_ready !== 1'b0 || b0.f !== 16'd12 || b0.rem !== 17'd6 ||
          b0.g0 !== 16'h1234 || b0.g1 !== 16'hABCD || b0.quad !== 2'd2 || b1.f !== 16'd12) begin
        nFail++;
        $display("[TB] FAIL bp_hold[%0d]: got v=%b rdy=%b f=%0d rem=%0d g0=%h g1=%h q=%0d fr=%0d, expected v=1 rdy=0 f=12 rem=6 g0=1234 g1=abcd q=2 fr=12",
                 k, b0.out_valid, b0.in_ready, b0.f, b0.rem, b0.g0, b0.g1, b0.quad, b1.f);
      end
    end
    applyStimulus(1'b0, 32'd0, 16'd0, 16'd0, 2'd0);
    setReady(1'b1);
    @(posedge clk);
    #1;
    setReady(1'b0);
    nChecks++;
    if (b0.out_valid !== 1'b0 || b0.in_ready !== 1'b1 || b0.g0 !== 16'h1234 || b0.f !== 16'd12) begin
      nFail++;
      $display("[TB] FAIL bp_release: got v=%b rdy=%b g0=%h f=%0d, expected v=0 rdy=1 g0=1234 f=12",
               b0.out_valid, b0.in_ready, b0.g0, b0.f);
    end
  endtask

  task automatic test_reset_in_calc();
    int   cycles;
    logic sawValid;
    @(negedge clk);
    applyStimulus(1'b1, 32'd999, 16'h0F0F, 16'hF0F0, 2'd3);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 32'd0, 16'd0, 16'd0, 2'd0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    nChecks++;
    if (b0.in_ready !== 1'b1 || b1.in_ready !== 1'b1 || b0.out_valid !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL calc_reset_ready: got in_ready=%b/%b out_valid=%b, expected 1/1 0",
               b0.in_ready, b1.in_ready, b0.out_valid);
    end
    sawValid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (b0.out_valid !== 1'b0 || b1.out_valid !== 1'b0) sawValid = 1'b1;
    end
    nChecks++;
    if (sawValid !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL calc_reset_no_valid: got out_valid pulse=%b, expected 0", sawValid);
    end
    @(negedge clk);
    applyStimulus(1'b1, 32'd1000000, 16'h0001, 16'h0002, 2'd1);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 32'd0, 16'd0, 16'd0, 2'd0);
    cycles = 0;
    while (b0.out_valid !== 1'b1 && cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    nChecks++;
    if (cycles != 16 || b0.f !== 16'd1000 || b0.rem !== 17'd0 || b1.f !== 16'd1000 || b0.g0 !== 16'h0001) begin
      nFail++;
      $display("[TB] FAIL calc_reset_next_op: got cycles=%0d f=%0d rem=%0d fr=%0d g0=%h, expected 16 1000 0 1000 0001",
               cycles, b0.f, b0.rem, b1.f, b0.g0);
    end
    setReady(1'b1);
    @(posedge clk);
    #1;
    setReady(1'b0);
  endtask

  initial begin
    nChecks = 0;
    nFail   = 0;
    rst     = 1'b1;
    applyStimulus(1'b0, 32'd0, 16'd0, 16'd0, 2'd0);
    setReady(1'b0);
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_in_calc();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
